// File: rtl/approx_add_pipe.sv
// Pipelined W-bit adder with run-time LOA low part; latency STAGES cycles, one pair per cycle.
// Backpressure: a single global stall; in_ready = ~out_valid | out_ready, all stages hold otherwise.
module approx_add_pipe #(
    parameter int W           = 20,
    parameter int STAGES      = 2,
    parameter int APPROX_BITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic         approx_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   res
);

    localparam int SEG  = (W + STAGES - 1) / STAGES;
    localparam int AIDX = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;
    localparam logic [W-1:0] LOW_MASK =
        (APPROX_BITS == 0) ? '0 : ({W{1'b1}} >> (W - APPROX_BITS));

    logic         vld_q [STAGES];
    logic         vld_d [STAGES];
    logic [W-1:0] a_q   [STAGES];
    logic [W-1:0] a_d   [STAGES];
    logic [W-1:0] b_q   [STAGES];
    logic [W-1:0] b_d   [STAGES];
    logic [W-1:0] lor_q [STAGES];
    logic [W-1:0] lor_d [STAGES];
    logic [W:0]   sum_q [STAGES];
    logic [W:0]   sum_d [STAGES];
    logic         cy_q  [STAGES];
    logic         cy_d  [STAGES];

    logic         advance;
    logic [W-1:0] a_mod, b_mod, lor_in;
    logic         loa_cy;
    logic [W-1:0] pa, pb, pl;
    logic [W:0]   ps, s;
    logic         pc, pv, cy;

    assign advance   = ~vld_q[STAGES-1] | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[STAGES-1];
    assign res       = sum_q[STAGES-1];

    // LOA is folded into the operands: the OR region is zeroed and bit A-1 of
    // both operands is set to the boundary carry, so 2*c ripples exactly c into
    // bit A and leaves the low sum bits at zero for the OR bits to fill later.
    always_comb begin
        a_mod  = in1;
        b_mod  = in2;
        lor_in = '0;
        loa_cy = in1[AIDX] & in2[AIDX];
        if ((APPROX_BITS > 0) && approx_en) begin
            a_mod       = in1 & ~LOW_MASK;
            b_mod       = in2 & ~LOW_MASK;
            a_mod[AIDX] = loa_cy;
            b_mod[AIDX] = loa_cy;
            lor_in      = (in1 | in2) & LOW_MASK;
        end
    end

    always_comb begin
        pa = '0;
        pb = '0;
        pl = '0;
        ps = '0;
        pc = 1'b0;
        pv = 1'b0;
        cy = 1'b0;
        s  = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                pa = a_mod;
                pb = b_mod;
                pl = lor_in;
                ps = '0;
                pc = 1'b0;
                pv = in_valid;
            end else begin
                pa = a_q[k-1];
                pb = b_q[k-1];
                pl = lor_q[k-1];
                ps = sum_q[k-1];
                pc = cy_q[k-1];
                pv = vld_q[k-1];
            end
            cy = pc;
            s  = ps;
            for (int i = 0; i < W; i++) begin
                if ((i >= k * SEG) && (i < (k + 1) * SEG)) begin
                    s[i] = pa[i] ^ pb[i] ^ cy;
                    cy   = (pa[i] & pb[i]) | (cy & (pa[i] ^ pb[i]));
                end
            end
            if (k == STAGES - 1) begin
                s[W]     = cy;
                s[W-1:0] = s[W-1:0] | pl;
            end
            a_d[k]   = pa;
            b_d[k]   = pb;
            lor_d[k] = pl;
            sum_d[k] = s;
            cy_d[k]  = cy;
            vld_d[k] = pv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                lor_q[k] <= '0;
                sum_q[k] <= '0;
                cy_q[k]  <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                lor_q[k] <= lor_d[k];
                sum_q[k] <= sum_d[k];
                cy_q[k]  <= cy_d[k];
            end
        end
    end

    // The last stage's operand/carry copies have no consumer.
    logic unused_last;
    assign unused_last = ^{a_q[STAGES-1], b_q[STAGES-1], lor_q[STAGES-1], cy_q[STAGES-1]};

endmodule
